// File: rtl/flag_pkg.sv
// Shared types and defaults for the flag/shadow unit and its interrupt front end.
package flag_pkg;

    typedef enum logic {NORMAL, ISR} isr_state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/intr_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by a rising-edge
// detector; edge_pulse is high for exactly one clock per synchronised 0->1.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/flag_shadow_unit.sv
// Architectural C/Z flags with interrupt shadow copies, interrupt enable,
// pending-interrupt latch and the NORMAL/ISR service state.
module flag_shadow_unit
    import flag_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic IE_RESET    = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_Z_LD,
    input  logic SEI,
    input  logic CLI,
    input  logic INTR,
    input  logic INT_ACK,
    input  logic RETIE,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic IE_FLAG,
    output logic INT_REQ,
    output logic IN_ISR
);

    isr_state_t state_q, state_d;
    logic       c_q, z_q, shad_c_q, shad_z_q, ie_q, pend_q, req_q;
    logic       c_d, z_d, shad_c_d, shad_z_d, ie_d, pend_d;
    logic       ack_acc, ret_acc, intr_edge;

    intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK        (CLK),
        .RST        (RST),
        .async_in   (INTR),
        .edge_pulse (intr_edge)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= NORMAL;
        else     state_q <= state_d;
    end

    always_comb begin
        ack_acc = INT_ACK && (state_q == NORMAL);
        ret_acc = RETIE && (state_q == ISR);
        state_d = state_q;
        if (ret_acc)      state_d = NORMAL;
        else if (ack_acc) state_d = ISR;
    end

    always_comb begin
        c_d      = c_q;
        z_d      = z_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        ie_d     = ie_q;
        if (FLG_C_CLR)      c_d = 1'b0;
        else if (FLG_C_SET) c_d = 1'b1;
        else if (FLG_C_LD)  c_d = C_IN;
        if (FLG_Z_LD)       z_d = Z_IN;
        // Shadows take the post-write values so a flag update in the ack cycle survives.
        if (ack_acc) begin
            shad_c_d = c_d;
            shad_z_d = z_d;
        end
        if (ret_acc) begin
            c_d = shad_c_q;
            z_d = shad_z_q;
        end
        if (ret_acc)      ie_d = 1'b1;
        else if (ack_acc) ie_d = 1'b0;
        else if (CLI)     ie_d = 1'b0;
        else if (SEI)     ie_d = 1'b1;
        // A new edge wins over the clear so it is never lost; a colliding RETIE keeps pending.
        pend_d = intr_edge | (pend_q & ~(INT_ACK & ~ret_acc));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
            ie_q     <= IE_RESET;
            pend_q   <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            req_q    <= pend_q & ie_q & (state_q != ISR);
        end
    end

    assign C_FLAG  = c_q;
    assign Z_FLAG  = z_q;
    assign SHAD_C  = shad_c_q;
    assign SHAD_Z  = shad_z_q;
    assign IE_FLAG = ie_q;
    assign INT_REQ = req_q;
    assign IN_ISR  = (state_q == ISR);

endmodule
